keypad_code_lock: RTL and testbench

- Consumes the debounced key stream produced by the 4x4 keypad scanner: a 4-bit key code plus a level-high "key stable" flag.
- Turns the stream into a fixed-length PIN entry and compares the entry against a parameterised code.
- Drives an unlock pulse and a lockout alarm.
- Sits between the scanner and the display/actuator logic on the lab board.

---
 rtl/keypad_pkg.sv | 18 +
 rtl/key_edge_detect.sv | 27 ++
 rtl/keypad_code_lock.sv | 125 ++++++++++++
 tb/tb_keypad_code_lock.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared key codes, digit width and lock state encoding
package keypad_pkg;

  localparam int DIGIT_W = 4;
  localparam int TIMER_W = 28;

  localparam logic [DIGIT_W-1:0] KEY_CLEAR = 4'd10;
  localparam logic [DIGIT_W-1:0] KEY_ENTER = 4'd11;
  localparam logic [DIGIT_W-1:0] KEY_BKSP  = 4'd12;

  typedef enum logic [1:0] {
    ST_ENTRY,
    ST_CHECK,
    ST_OPEN,
    ST_LOCKOUT
  } state_t;

endpackage

// File: rtl/key_edge_detect.sv
// rtl/key_edge_detect.sv - one-cycle event on the rising edge of the scanner key-stable level
module key_edge_detect
  import keypad_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               key_valid,
  input  logic [DIGIT_W-1:0] key_num,
  output logic               key_evt,
  output logic [DIGIT_W-1:0] key_code
);

  logic key_valid_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_valid_q <= 1'b0;
    end else begin
      key_valid_q <= key_valid;
    end
  end

  // The code is taken in the event cycle itself so the entry buffer updates on the same edge.
  assign key_evt  = key_valid & ~key_valid_q;
  assign key_code = key_num;

endmodule

// File: rtl/keypad_code_lock.sv
// rtl/keypad_code_lock.sv - PIN entry buffer, code check, open timer and lockout alarm
module keypad_code_lock
  import keypad_pkg::*;
#(
  parameter int                         DIGITS      = 4,
  parameter logic [DIGIT_W*DIGITS-1:0]  CODE        = 16'h1234,
  parameter int                         MAX_FAIL    = 3,
  parameter int                         OPEN_CYCLES = 50_000_000,
  parameter int                         LOCK_CYCLES = 250_000_000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        key_valid,
  input  logic [DIGIT_W-1:0]          key_num,
  output logic [DIGIT_W*DIGITS-1:0]   digits,
  output logic [3:0]                  count,
  output logic                        unlocked,
  output logic                        alarm,
  output logic [2:0]                  fail_cnt
);

  localparam int DW = DIGIT_W * DIGITS;

  state_t               state;
  logic [TIMER_W-1:0]   timer;
  logic                 key_evt;
  logic [DIGIT_W-1:0]   key_code;
  logic                 is_digit;
  logic                 match;
  logic [2:0]           fail_next;

  key_edge_detect u_key_edge_detect (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_valid(key_valid),
    .key_num  (key_num),
    .key_evt  (key_evt),
    .key_code (key_code)
  );

  always_comb begin
    is_digit  = (key_code < 4'd10);
    match     = (count == 4'(DIGITS)) && (digits == CODE);
    fail_next = (fail_cnt >= 3'(MAX_FAIL)) ? 3'(MAX_FAIL) : fail_cnt + 3'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_ENTRY;
      digits   <= '0;
      count    <= '0;
      unlocked <= 1'b0;
      alarm    <= 1'b0;
      fail_cnt <= '0;
      timer    <= '0;
    end else begin
      case (state)
        ST_ENTRY: begin
          if (key_evt) begin
            if (is_digit) begin
              if (count < 4'(DIGITS)) begin
                digits <= (digits << DIGIT_W) | DW'(key_code);
                count  <= count + 4'd1;
              end
            end else if (key_code == KEY_CLEAR) begin
              digits <= '0;
              count  <= '0;
            end else if (key_code == KEY_BKSP) begin
              if (count != 4'd0) begin
                digits <= digits >> DIGIT_W;
                count  <= count - 4'd1;
              end
            end else if (key_code == KEY_ENTER) begin
              state <= ST_CHECK;
            end
          end
        end

        ST_CHECK: begin
          digits <= '0;
          count  <= '0;
          if (match) begin
            state    <= ST_OPEN;
            fail_cnt <= '0;
            unlocked <= 1'b1;
            timer    <= TIMER_W'(OPEN_CYCLES - 1);
          end else begin
            fail_cnt <= fail_next;
            if (fail_next == 3'(MAX_FAIL)) begin
              state <= ST_LOCKOUT;
              alarm <= 1'b1;
              timer <= TIMER_W'(LOCK_CYCLES - 1);
            end else begin
              state <= ST_ENTRY;
            end
          end
        end

        ST_OPEN: begin
          // CLEAR is the only key honoured while open: it relocks at once.
          if ((key_evt && key_code == KEY_CLEAR) || timer == '0) begin
            state    <= ST_ENTRY;
            unlocked <= 1'b0;
            timer    <= '0;
          end else begin
            timer <= timer - TIMER_W'(1);
          end
        end

        ST_LOCKOUT: begin
          if (timer == '0) begin
            state    <= ST_ENTRY;
            alarm    <= 1'b0;
            fail_cnt <= '0;
          end else begin
            timer <= timer - TIMER_W'(1);
          end
        end

        default: state <= ST_ENTRY;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_code_lock.sv
// tb/tb_keypad_code_lock.sv - randomized self-checking bench for keypad_code_lock
module tb_keypad_code_lock;

  localparam int OPEN_N = 20;
  localparam int LOCK_N = 30;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        key_valid;
  logic [3:0]  key_num;
  logic [15:0] digits;
  logic [3:0]  count;
  logic        unlocked;
  logic        alarm;
  logic [2:0]  fail_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: list of entered digits (oldest first) and failure count.
  int mq[$];
  int m_fail = 0;

  keypad_code_lock #(
    .DIGITS(4), .CODE(16'h1234), .MAX_FAIL(3),
    .OPEN_CYCLES(OPEN_N), .LOCK_CYCLES(LOCK_N)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_num(key_num),
    .digits(digits), .count(count), .unlocked(unlocked), .alarm(alarm),
    .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] m_digits();
    logic [15:0] v = '0;
    foreach (mq[i]) v = (v << 4) | 16'(mq[i]);
    return v;
  endfunction

  // Outcome of a key in ENTRY: 0 stay in entry, 1 open, 2 lockout.
  task automatic model_key(input int k, output int outcome);
    outcome = 0;
    if (k < 10) begin
      if (mq.size() < 4) mq.push_back(k);
    end else if (k == 10) begin
      mq.delete();
    end else if (k == 12) begin
      if (mq.size() > 0) void'(mq.pop_back());
    end else if (k == 11) begin
      if (mq.size() == 4 && m_digits() == 16'h1234) begin
        m_fail = 0;
        outcome = 1;
      end else begin
        m_fail = (m_fail + 1 > 3) ? 3 : m_fail + 1;
        outcome = (m_fail == 3) ? 2 : 0;
      end
      mq.delete();
    end
  endtask

  task automatic press(input logic [3:0] k, input int hold);
    @(posedge clk); #1;
    key_valid = 1'b1;
    key_num   = k;
    repeat (hold) @(posedge clk);
    #1 key_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic press_model(input int k);
    int o;
    press(4'(k), 5);
    model_key(k, o);
  endtask

  // ENTER, then measure cycles to the rise of unlocked/alarm and how long it stays high.
  task automatic measure(input bit watch_alarm, input bit poke, output int dly, output int len);
    @(posedge clk); #1;
    key_valid = 1'b1;
    key_num   = 4'd11;
    dly = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (watch_alarm ? alarm : unlocked) break;
      dly++;
    end
    key_valid = 1'b0;
    len = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!(watch_alarm ? alarm : unlocked)) break;
      len++;
      if (poke && len < 24) begin
        if (len % 4 == 0) key_num = 4'($urandom_range(0, 15));
        key_valid = ((len % 4) < 2);
      end else begin
        key_valid = 1'b0;
      end
    end
    key_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; key_valid = 1'b0; key_num = 4'd0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({digits, count, unlocked, alarm, fail_cnt} !== 25'd0) begin
      errors++;
      $display("FAIL reset: got digits=%h count=%0d unl=%b alarm=%b fail=%0d, want all 0",
               digits, count, unlocked, alarm, fail_cnt);
    end
  endtask

  task automatic test_correct_code();
    int o, dly, len;
    press_model(1); press_model(2); press_model(3); press_model(4);
    checks++;
    if (digits !== m_digits() || count !== 4'(mq.size())) begin
      errors++;
      $display("FAIL code_entry: got %h/%0d want %h/%0d", digits, count, m_digits(), mq.size());
    end
    model_key(11, o);
    measure(1'b0, 1'b0, dly, len);
    checks++;
    if (o != 1 || dly != 2) begin
      errors++;
      $display("FAIL open_delay: got %0d cycles (model outcome %0d) want 2 with outcome 1", dly, o);
    end
    checks++;
    if (len != OPEN_N) begin
      errors++;
      $display("FAIL open_length: got %0d want %0d", len, OPEN_N);
    end
    checks++;
    if (fail_cnt !== 3'(m_fail) || count !== 4'd0 || m_fail != 0) begin
      errors++;
      $display("FAIL open_after: got fail=%0d count=%0d want fail=0 count=0", fail_cnt, count);
    end
  endtask

  task automatic test_held_key();
    int o;
    press(4'd7, 100);
    model_key(7, o);
    checks++;
    if (digits !== m_digits() || count !== 4'(mq.size())) begin
      errors++;
      $display("FAIL held_key: got %h/%0d want %h/%0d", digits, count, m_digits(), mq.size());
    end
    press_model(10);
  endtask

  task automatic test_overflow_backspace();
    for (int k = 1; k <= 5; k++) press_model(k);
    checks++;
    if (digits !== m_digits() || count !== 4'(mq.size())) begin
      errors++;
      $display("FAIL overflow: got %h/%0d want %h/%0d", digits, count, m_digits(), mq.size());
    end
    press_model(12);
    checks++;
    if (digits !== m_digits() || count !== 4'(mq.size())) begin
      errors++;
      $display("FAIL backspace: got %h/%0d want %h/%0d", digits, count, m_digits(), mq.size());
    end
    press_model(10);
    checks++;
    if (digits !== m_digits() || count !== 4'(mq.size())) begin
      errors++;
      $display("FAIL clear: got %h/%0d want %h/%0d", digits, count, m_digits(), mq.size());
    end
  endtask

  task automatic test_lockout();
    int o, dly, len;
    for (int i = 0; i < 4; i++) press_model(4);
    press_model(11);
    checks++;
    if (fail_cnt !== 3'(m_fail) || alarm !== 1'b0) begin
      errors++;
      $display("FAIL fail_step1: got fail=%0d alarm=%b want fail=%0d alarm=0", fail_cnt, alarm, m_fail);
    end
    press_model(11);
    checks++;
    if (fail_cnt !== 3'(m_fail) || alarm !== 1'b0) begin
      errors++;
      $display("FAIL fail_step2: got fail=%0d alarm=%b want fail=%0d alarm=0", fail_cnt, alarm, m_fail);
    end
    for (int i = 0; i < 4; i++) press_model(9);
    model_key(11, o);
    measure(1'b1, 1'b1, dly, len);
    if (o == 2) m_fail = 0;
    checks++;
    if (o != 2 || dly != 2) begin
      errors++;
      $display("FAIL alarm_delay: got %0d cycles (model outcome %0d) want 2 with outcome 2", dly, o);
    end
    checks++;
    if (len != LOCK_N) begin
      errors++;
      $display("FAIL lock_length: got %0d want %0d", len, LOCK_N);
    end
    checks++;
    if (count !== 4'd0 || digits !== 16'd0 || fail_cnt !== 3'(m_fail)) begin
      errors++;
      $display("FAIL lock_after: got count=%0d digits=%h fail=%0d want 0/0/%0d",
               count, digits, fail_cnt, m_fail);
    end
  endtask

  task automatic test_relock_reset();
    for (int k = 1; k <= 4; k++) press_model(k);
    press_model(11);
    checks++;
    if (unlocked !== 1'b1) begin
      errors++;
      $display("FAIL relock_open: got unlocked=%b want 1", unlocked);
    end
    @(posedge clk); #1;
    key_valid = 1'b1; key_num = 4'd10;
    @(negedge clk);
    checks++;
    if (unlocked !== 1'b1) begin
      errors++;
      $display("FAIL relock_event_cycle: got unlocked=%b want 1", unlocked);
    end
    @(negedge clk);
    checks++;
    if (unlocked !== 1'b0) begin
      errors++;
      $display("FAIL relock_next_cycle: got unlocked=%b want 0", unlocked);
    end
    key_valid = 1'b0;
    repeat (3) press_model(11);
    checks++;
    if (alarm !== 1'b1 || fail_cnt !== 3'(m_fail)) begin
      errors++;
      $display("FAIL reset_pre_lock: got alarm=%b fail=%0d want 1/%0d", alarm, fail_cnt, m_fail);
    end
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    mq.delete();
    m_fail = 0;
    checks++;
    if ({digits, count, unlocked, alarm, fail_cnt} !== 25'd0) begin
      errors++;
      $display("FAIL reset_in_lockout: got digits=%h count=%0d unl=%b alarm=%b fail=%0d, want all 0",
               digits, count, unlocked, alarm, fail_cnt);
    end
  endtask

  task automatic test_ignored();
    press_model(1); press_model(2);
    for (int k = 13; k <= 15; k++) begin
      press_model(k);
      checks++;
      if (digits !== m_digits() || count !== 4'(mq.size())) begin
        errors++;
        $display("FAIL ignored_%0d: got %h/%0d want %h/%0d", k, digits, count, m_digits(), mq.size());
      end
    end
    press_model(3);
    checks++;
    if (digits !== m_digits() || count !== 4'(mq.size())) begin
      errors++;
      $display("FAIL ignored_then_digit: got %h/%0d want %h/%0d", digits, count, m_digits(), mq.size());
    end
    press_model(10);
  endtask

  task automatic test_random();
    int n, k, o, w;
    for (int r = 0; r < 12; r++) begin
      n = $urandom_range(0, 7);
      for (int j = 0; j < n; j++) begin
        k = $urandom_range(0, 15);
        if (k == 11) k = 12;
        press(4'(k), $urandom_range(1, 8));
        model_key(k, o);
        checks++;
        if (digits !== m_digits() || count !== 4'(mq.size())) begin
          errors++;
          $display("FAIL random_key r%0d k%0d: got %h/%0d want %h/%0d",
                   r, k, digits, count, m_digits(), mq.size());
        end
      end
      press(4'd11, 5);
      model_key(11, o);
      checks++;
      if (unlocked !== (o == 1) || alarm !== (o == 2) || fail_cnt !== 3'(m_fail)) begin
        errors++;
        $display("FAIL random_enter r%0d: got unl=%b alarm=%b fail=%0d want unl=%0d alarm=%0d fail=%0d",
                 r, unlocked, alarm, fail_cnt, o == 1, o == 2, m_fail);
      end
      w = 0;
      while ((unlocked || alarm) && w < 100) begin
        @(negedge clk);
        w++;
      end
      if (o == 2) m_fail = 0;
      checks++;
      if (w >= 100) begin
        errors++;
        $display("FAIL random_exit r%0d: still open/alarm after %0d cycles, want release", r, w);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_correct_code();
    test_held_key();
    test_overflow_backspace();
    test_lockout();
    test_relock_reset();
    test_ignored();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
